// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave round-robin arbiter for the picorv32
// native memory bus. The grant is held for a whole transaction, and a watchdog
// completes transactions that the slave never acknowledges.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   m0_mem_*             master 0 (CPU): valid/instr/wstrb/wdata/addr in,
//                        ready/rdata out
//   m1_mem_*             master 1 (secondary requester), same set as master 0
//   s_mem_*              slave side: valid/instr/wstrb/wdata/addr out,
//                        ready/rdata in
//   grant                one-hot owner {m1,m0}; 2'b00 while idle
//   timeout_err          sticky watchdog-expiry flag; cleared only by reset
//
// Parameters:
//   TIMEOUT_CYCLES       busy cycles without s_mem_ready before forced
//                        completion; 0 disables the watchdog
//   ERR_DATA             rdata returned to the master on a timed-out transaction
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_mem_valid,
    output logic        m0_mem_ready,
    input  logic        m0_mem_instr,
    input  logic [3:0]  m0_mem_wstrb,
    input  logic [31:0] m0_mem_wdata,
    input  logic [31:0] m0_mem_addr,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    output logic        m1_mem_ready,
    input  logic        m1_mem_instr,
    input  logic [3:0]  m1_mem_wstrb,
    input  logic [31:0] m1_mem_wdata,
    input  logic [31:0] m1_mem_addr,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    input  logic        s_mem_ready,
    output logic        s_mem_instr,
    output logic [3:0]  s_mem_wstrb,
    output logic [31:0] s_mem_wdata,
    output logic [31:0] s_mem_addr,
    input  logic [31:0] s_mem_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    // One spare bit so the counter can never wrap before it reaches the limit.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             last_served;      // 0 = master 0 served last, 1 = master 1
    logic             next_last;
    logic [CNT_W-1:0] wdog_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_err;
    logic [1:0]       next_grant;

    // Signals of whichever master currently owns the bus.
    logic             busy;
    logic             owner;
    logic             own_valid;
    logic             own_instr;
    logic [3:0]       own_wstrb;
    logic [31:0]      own_wdata;
    logic [31:0]      own_addr;
    logic             expire;
    logic             own_ready;
    logic [31:0]      own_rdata;

    // State register; grant is registered as a decode of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_served <= 1'b1;
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            grant       <= next_grant;
            last_served <= next_last;
            wdog_cnt    <= next_cnt;
            timeout_err <= next_err;
        end
    end

    // Next-state, owner mux, watchdog and bus outputs.
    always_comb begin
        next_state   = state;
        next_last    = last_served;
        next_cnt     = wdog_cnt;
        next_err     = timeout_err;
        next_grant   = 2'b00;

        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_wstrb  = 4'b0000;
        s_mem_wdata  = 32'h0;
        s_mem_addr   = 32'h0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = 32'h0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = 32'h0;

        busy      = (state == BUSY0) || (state == BUSY1);
        owner     = (state == BUSY1);
        own_valid = owner ? m1_mem_valid : m0_mem_valid;
        own_instr = owner ? m1_mem_instr : m0_mem_instr;
        own_wstrb = owner ? m1_mem_wstrb : m0_mem_wstrb;
        own_wdata = owner ? m1_mem_wdata : m0_mem_wdata;
        own_addr  = owner ? m1_mem_addr  : m0_mem_addr;

        // A slave acknowledge in the expiry cycle wins over the watchdog.
        expire    = busy && WDOG_EN && own_valid && !s_mem_ready && (wdog_cnt == CNT_LAST);
        own_ready = expire ? 1'b1 : s_mem_ready;
        own_rdata = expire ? ERR_DATA : s_mem_rdata;

        unique case (state)
            IDLE: begin
                next_cnt = '0;
                // Tie goes to the master that was not served last.
                if (m0_mem_valid && (!m1_mem_valid || last_served)) begin
                    next_state = BUSY0;
                end else if (m1_mem_valid) begin
                    next_state = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                s_mem_valid = own_valid && !expire;
                s_mem_instr = own_instr;
                s_mem_wstrb = own_wstrb;
                s_mem_wdata = own_wdata;
                s_mem_addr  = own_addr;
                if (owner) begin
                    m1_mem_ready = own_ready;
                    m1_mem_rdata = own_rdata;
                end else begin
                    m0_mem_ready = own_ready;
                    m0_mem_rdata = own_rdata;
                end

                if (!own_valid) begin
                    // Master abandoned the request: release without touching fairness.
                    next_state = IDLE;
                end else if (s_mem_ready) begin
                    next_state = IDLE;
                    next_last  = owner;
                end else if (expire) begin
                    next_state = IDLE;
                    next_last  = owner;
                    next_err   = 1'b1;
                end else if (WDOG_EN) begin
                    next_cnt = wdog_cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        unique case (next_state)
            BUSY0:   next_grant = 2'b01;
            BUSY1:   next_grant = 2'b10;
            default: next_grant = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8).
// Two master agents replay request queues, a behavioural slave acknowledges
// after a programmable latency, and a scoreboard of expected read data per
// master is consumed whenever the DUT pulses a master's ready.
module tb_mem_arbiter;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  w0;
        logic [3:0]  w1;
        int          lat;
        logic [1:0]  xa;
        logic [1:0]  xb;
        logic        xerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_mem_valid, m0_mem_ready, m0_mem_instr;
    logic [3:0]  m0_mem_wstrb;
    logic [31:0] m0_mem_wdata, m0_mem_addr, m0_mem_rdata;
    logic        m1_mem_valid, m1_mem_ready, m1_mem_instr;
    logic [3:0]  m1_mem_wstrb;
    logic [31:0] m1_mem_wdata, m1_mem_addr, m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr;
    logic        s_mem_ready = 1'b0;
    logic [3:0]  s_mem_wstrb;
    logic [31:0] s_mem_wdata, s_mem_addr;
    logic [31:0] s_mem_rdata = 32'h0;
    logic [1:0]  grant;
    logic        timeout_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_mem_valid(m0_mem_valid), .m0_mem_ready(m0_mem_ready), .m0_mem_instr(m0_mem_instr),
        .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_wdata(m0_mem_wdata), .m0_mem_addr(m0_mem_addr),
        .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_ready(m1_mem_ready), .m1_mem_instr(m1_mem_instr),
        .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_wdata(m1_mem_wdata), .m1_mem_addr(m1_mem_addr),
        .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_ready(s_mem_ready), .s_mem_instr(s_mem_instr),
        .s_mem_wstrb(s_mem_wstrb), .s_mem_wdata(s_mem_wdata), .s_mem_addr(s_mem_addr),
        .s_mem_rdata(s_mem_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          sl_lat = 0;
    int          sl_cnt = 0;
    req_t        q0[$];
    req_t        q1[$];
    logic [31:0] e0[$];
    logic [31:0] e1[$];
    logic [1:0]  glog[$];
    req_t        cur0, cur1;
    logic        active0 = 1'b0, active1 = 1'b0;
    logic        done0 = 1'b0, done1 = 1'b0;
    logic [1:0]  prev_g = 2'b00;
    int          busy_cnt = 0;
    int          last_len = 0;
    vec_t        vec[7];

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'h12345778;
    endfunction

    // Slave: registered ready in busy cycle sl_lat+2; sl_lat < 0 never answers.
    always @(posedge clk) begin
        if (reset) begin
            s_mem_ready <= 1'b0;
            s_mem_rdata <= 32'h0;
            sl_cnt      <= 0;
        end else begin
            if (s_mem_valid && !s_mem_ready && sl_lat >= 0 && sl_cnt == sl_lat) begin
                s_mem_ready <= 1'b1;
                s_mem_rdata <= slave_data(s_mem_addr);
            end else begin
                s_mem_ready <= 1'b0;
                s_mem_rdata <= 32'h0BAD0000 | 32'(sl_cnt);
            end
            sl_cnt <= (s_mem_valid && !s_mem_ready) ? sl_cnt + 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached / unexpected event", nm);
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [3:0] w);
        req_t r;
        r.addr  = a;
        r.wstrb = w;
        r.wdata = (w != 4'h0) ? (a ^ 32'hCAFE0000) : 32'h0;
        r.instr = (w == 4'h0) && a[8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (sl_lat < 0 || sl_lat > int'(TO) - 2) return ERR;
        return slave_data(a);
    endfunction

    // Per-cycle observation: ownership invariants, forwarding, scoreboard.
    task automatic mon();
        if (grant != 2'b00) busy_cnt++; else busy_cnt = 0;
        chk("grant_onehot", 128'(grant == 2'b11), 128'(0));
        if (prev_g != 2'b00 && grant != 2'b00 && grant != prev_g) fail_now("no_idle_gap");
        if (prev_g == 2'b00 && grant != 2'b00) glog.push_back(grant);
        prev_g = grant;
        if (grant != 2'b01) chk("m0_quiet", {m0_mem_ready, m0_mem_rdata}, 128'(0));
        if (grant != 2'b10) chk("m1_quiet", {m1_mem_ready, m1_mem_rdata}, 128'(0));
        if (grant == 2'b00)
            chk("s_idle", {s_mem_valid, s_mem_instr, s_mem_wstrb, s_mem_wdata, s_mem_addr}, 128'(0));
        if (s_mem_valid)
            chk("s_fwd", {s_mem_instr, s_mem_wstrb, s_mem_wdata, s_mem_addr},
                (grant == 2'b10) ? {m1_mem_instr, m1_mem_wstrb, m1_mem_wdata, m1_mem_addr}
                                 : {m0_mem_instr, m0_mem_wstrb, m0_mem_wdata, m0_mem_addr});
        if (grant == 2'b01 && m0_mem_valid && !(m0_mem_ready && !s_mem_ready))
            chk("s_valid_m0", 128'(s_mem_valid), 128'(1));
        if (grant == 2'b10 && m1_mem_valid && !(m1_mem_ready && !s_mem_ready))
            chk("s_valid_m1", 128'(s_mem_valid), 128'(1));
        if (m0_mem_ready) begin
            if (e0.size() == 0) fail_now("m0_unexpected_ready");
            else chk("m0_rdata", 128'(m0_mem_rdata), 128'(e0.pop_front()));
            if (!s_mem_ready) chk("m0_wdog_s_valid", 128'(s_mem_valid), 128'(0));
            done0    = 1'b1;
            last_len = busy_cnt;
        end
        if (m1_mem_ready) begin
            if (e1.size() == 0) fail_now("m1_unexpected_ready");
            else chk("m1_rdata", 128'(m1_mem_rdata), 128'(e1.pop_front()));
            if (!s_mem_ready) chk("m1_wdog_s_valid", 128'(s_mem_valid), 128'(0));
            done1    = 1'b1;
            last_len = busy_cnt;
        end
    endtask

    // Master agents: hold a request until ready, then present the next one.
    task automatic agents();
        if (done0) begin active0 = 1'b0; done0 = 1'b0; end
        if (done1) begin active1 = 1'b0; done1 = 1'b0; end
        if (!active0 && q0.size() != 0) begin
            cur0 = q0.pop_front(); active0 = 1'b1; e0.push_back(exp_rd(cur0.addr));
        end
        if (!active1 && q1.size() != 0) begin
            cur1 = q1.pop_front(); active1 = 1'b1; e1.push_back(exp_rd(cur1.addr));
        end
        m0_mem_valid = active0;
        m1_mem_valid = active1;
        {m0_mem_addr, m0_mem_wdata, m0_mem_wstrb, m0_mem_instr} = active0 ? cur0 : req_t'('0);
        {m1_mem_addr, m1_mem_wdata, m1_mem_wstrb, m1_mem_instr} = active1 ? cur1 : req_t'('0);
    endtask

    task automatic flush();
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
        active0 = 1'b0; active1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
        agents();
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        agents();
    endtask

    task automatic wait_grant(input logic [1:0] g);
        int n = 0;
        while (grant !== g && n < 50) begin step(); n++; end
        if (grant !== g) fail_now("wait_grant");
    endtask

    task automatic run_case(input string nm, input int lat, input logic [1:0] xa,
                            input logic [1:0] xb, input logic xerr);
        int n = 0;
        int xlen;
        step();
        while ((q0.size() != 0 || q1.size() != 0 || active0 || active1) && n < 400) begin
            step(); n++;
        end
        if (n >= 400) fail_now({nm, "_hang"});
        xlen = (lat < 0 || lat > int'(TO) - 2) ? int'(TO) : lat + 2;
        chk({nm, "_first"},  128'((glog.size() > 0) ? glog[0] : 2'b00), 128'(xa));
        chk({nm, "_second"}, 128'((glog.size() > 1) ? glog[1] : 2'b00), 128'(xb));
        chk({nm, "_count"},  128'(glog.size()), 128'(int'(xa != 2'b00) + int'(xb != 2'b00)));
        chk({nm, "_len"},    128'(last_len), 128'(xlen));
        chk({nm, "_err"},    128'(timeout_err), 128'(xerr));
        chk({nm, "_sb"},     128'(e0.size() + e1.size()), 128'(0));
    endtask

    initial begin
        req_t r;
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        req_t r;
        // {v0, v1, a0, a1, w0, w1, slave latency, first grant, second grant, timeout_err}
        vec[0] = '{1'b1, 1'b0, 32'h100, 32'h0,   4'h0, 4'h0, 0,  2'b01, 2'b00, 1'b0};
        vec[1] = '{1'b1, 1'b1, 32'h300, 32'h304, 4'h0, 4'h0, 0,  2'b10, 2'b01, 1'b0};
        vec[2] = '{1'b0, 1'b1, 32'h0,   32'h200, 4'h0, 4'h0, 2,  2'b10, 2'b00, 1'b0};
        vec[3] = '{1'b1, 1'b1, 32'h400, 32'h404, 4'hF, 4'h3, 1,  2'b01, 2'b10, 1'b0};
        vec[4] = '{1'b1, 1'b0, 32'h600, 32'h0,   4'h0, 4'h0, 6,  2'b01, 2'b00, 1'b0};
        vec[5] = '{1'b1, 1'b0, 32'h700, 32'h0,   4'h0, 4'h0, -1, 2'b01, 2'b00, 1'b1};
        vec[6] = '{1'b1, 1'b1, 32'h800, 32'h804, 4'h0, 4'h0, 0,  2'b10, 2'b01, 1'b1};

        reset = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {grant, timeout_err, s_mem_valid, m0_mem_ready, m1_mem_ready}, 128'(0));
        chk("reset_data", {m0_mem_rdata, m1_mem_rdata, s_mem_wstrb, s_mem_addr}, 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            sl_lat = vec[i].lat;
            glog.delete();
            if (vec[i].v0) q0.push_back(mk(vec[i].a0, vec[i].w0));
            if (vec[i].v1) q1.push_back(mk(vec[i].a1, vec[i].w1));
            run_case($sformatf("row%0d", i), vec[i].lat, vec[i].xa, vec[i].xb, vec[i].xerr);
        end

        // Reset in the middle of a master-1 transaction, then a tie from fresh reset.
        sl_lat = -1;
        glog.delete();
        q1.push_back(mk(32'h500, 4'h0));
        wait_grant(2'b10);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_mid_grant", 128'(grant), 128'(0));
        chk("rst_mid_s_valid", 128'(s_mem_valid), 128'(0));
        chk("rst_mid_m1_ready", 128'(m1_mem_ready), 128'(0));
        chk("rst_mid_err_clr", 128'(timeout_err), 128'(0));
        reset = 1'b0;
        flush();
        step();
        sl_lat = 0;
        glog.delete();
        q0.push_back(mk(32'hA00, 4'h0));
        q1.push_back(mk(32'hA04, 4'h0));
        run_case("rst_then_tie", 0, 2'b01, 2'b10, 1'b0);

        // Master-1 write held until ready while master 0 requests mid-transaction.
        sl_lat = 3;
        glog.delete();
        r = mk(32'h40, 4'b0011);
        r.wdata = 32'hAABBCCDD;
        q1.push_back(r);
        wait_grant(2'b10);
        step();
        chk("m1_write_fwd", {s_mem_valid, s_mem_wstrb, s_mem_wdata, s_mem_addr},
            {1'b1, 4'b0011, 32'hAABBCCDD, 32'h40});
        q0.push_back(mk(32'h80, 4'h0));
        run_case("m1_write_then_m0", 3, 2'b10, 2'b01, 1'b0);

        // Master 0 abandons; fairness pointer (master 0 last) must be untouched.
        sl_lat = -1;
        glog.delete();
        q0.push_back(mk(32'h900, 4'h0));
        wait_grant(2'b01);
        repeat (2) step();
        flush();
        step();
        chk("abandon_idle", {grant, m0_mem_ready, s_mem_valid}, 128'(0));
        step();
        sl_lat = 0;
        glog.delete();
        q0.push_back(mk(32'hB00, 4'h0));
        q1.push_back(mk(32'hB04, 4'h0));
        run_case("abandon_keeps_ptr", 0, 2'b10, 2'b01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
